// File: rtl/juego_led_control_pkg.sv
// Shared definitions for the LED tug-of-war sequencer: state encodings,
// counter widths and default prescaler values.
package juego_led_control_pkg;

  localparam int unsigned CUENTA_W     = 4;
  localparam int unsigned ESTADO_W     = 3;
  localparam int unsigned TICK_DIV_SYN = 50000000;
  localparam int unsigned TICK_DIV_SIM = 4;

  typedef logic [ESTADO_W-1:0] estado_t;

  localparam logic [2:0] APAGADO = 3'd0;
  localparam logic [2:0] CUENTA  = 3'd1;
  localparam logic [2:0] JUEGO   = 3'd2;
  localparam logic [2:0] GANA_A  = 3'd3;
  localparam logic [2:0] GANA_B  = 3'd4;

  // True in either winner-display state.
  function automatic logic esGanador(input estado_t s);
    return (s == GANA_A) || (s == GANA_B);
  endfunction

endpackage

// File: rtl/juego_led_control_if.sv
// Player controls and display/status bundle between the buttons, the
// sequencer and the LED bar / counter datapath.
interface juego_led_control_if
  import juego_led_control_pkg::*;
#(
  parameter int unsigned N_LEDS = 8
);

  logic                inicio;
  logic                apagar;
  logic                botonA;
  logic                botonB;
  logic [N_LEDS-1:0]   leds;
  logic                ganadorA;
  logic                ganadorB;
  logic                resetContador;
  logic                jugando;
  logic [CUENTA_W-1:0] cuenta;

  modport master (
    output inicio, apagar, botonA, botonB,
    input  leds, ganadorA, ganadorB, resetContador, jugando, cuenta
  );

  modport slave (
    input  inicio, apagar, botonA, botonB,
    output leds, ganadorA, ganadorB, resetContador, jugando, cuenta
  );

endinterface

// File: rtl/juego_led_control_divisor_tick.sv
// Game-tick prescaler: counts 0..TICK_DIV-1 and pulses tick for one clk while
// the count sits at its last value; clr restarts the count from 0.
module divisor_tick #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic resetTotal,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;

  always_comb begin
    cntNext = cnt + CNT_W'(1);
    if (clr || (cnt == CNT_W'(TICK_DIV - 1))) begin
      cntNext = '0;
    end
  end

  // tick is registered from the next count so it lines up with the wrap value.
  always_ff @(posedge clk or posedge resetTotal) begin
    if (resetTotal) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cntNext;
      tick <= (cntNext == CNT_W'(TICK_DIV - 1));
    end
  end

endmodule

// File: rtl/juego_led_control.sv
// Two-player LED tug-of-war sequencer: game FSM, lit-LED position, winner
// detection and LED bar decode. All outputs come straight from registers.
module juego_led_control
  import juego_led_control_pkg::*;
#(
  parameter int unsigned N_LEDS     = 8,
  parameter int unsigned POS_W      = 3,
  parameter int unsigned TICK_DIV   = TICK_DIV_SYN,
  parameter int unsigned CUENTA_INI = 3,
  parameter int unsigned T_GANADOR  = 5
) (
  input logic                clk,
  input logic                resetTotal,
  juego_led_control_if.slave bus
);

  localparam int unsigned GAN_W = (T_GANADOR > 1) ? $clog2(T_GANADOR + 1) : 1;
  localparam logic [POS_W-1:0] POS_INI = POS_W'(N_LEDS / 2);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LEDS - 1);

  estado_t             state;
  estado_t             stateNext;
  logic [POS_W-1:0]    pos;
  logic [POS_W-1:0]    posNext;
  logic [CUENTA_W-1:0] cuenta;
  logic [CUENTA_W-1:0] cuentaNext;
  logic [GAN_W-1:0]    ganCnt;
  logic [GAN_W-1:0]    ganCntNext;
  logic [N_LEDS-1:0]   ledsReg;
  logic [N_LEDS-1:0]   ledsNext;
  logic                prevA;
  logic                prevB;
  logic                pulseA;
  logic                pulseB;
  logic                restart;
  logic                clr;
  logic                tick;
  logic                ganadorAReg;
  logic                ganadorBReg;
  logic                resetContadorReg;
  logic                jugandoReg;

  assign clr = (stateNext != state) || restart;

  divisor_tick #(
    .TICK_DIV (TICK_DIV)
  ) uDivisor (
    .clk        (clk),
    .resetTotal (resetTotal),
    .clr        (clr),
    .tick       (tick)
  );

  // Next-state, position and display decode.
  always_comb begin
    stateNext  = state;
    posNext    = pos;
    cuentaNext = cuenta;
    ganCntNext = ganCnt;
    ledsNext   = ledsReg;
    restart    = 1'b0;

    case (state)
      APAGADO: begin
        if (bus.inicio) begin
          stateNext  = CUENTA;
          cuentaNext = CUENTA_W'(CUENTA_INI);
          posNext    = POS_INI;
        end
      end
      CUENTA: begin
        if (pulseA && pulseB) begin
          cuentaNext = CUENTA_W'(CUENTA_INI);
          restart    = 1'b1;
        end else if (pulseA) begin
          stateNext = GANA_B;
        end else if (pulseB) begin
          stateNext = GANA_A;
        end else if (tick) begin
          if (cuenta == CUENTA_W'(1)) begin
            stateNext = JUEGO;
          end else begin
            cuentaNext = cuenta - CUENTA_W'(1);
          end
        end
      end
      JUEGO: begin
        // Simultaneous presses cancel out; the win check uses the moved position.
        if (pulseA && !pulseB && (pos != POS_MAX)) begin
          posNext = pos + POS_W'(1);
          if (posNext == POS_MAX) begin
            stateNext = GANA_A;
          end
        end else if (pulseB && !pulseA && (pos != '0)) begin
          posNext = pos - POS_W'(1);
          if (posNext == '0) begin
            stateNext = GANA_B;
          end
        end
      end
      GANA_A, GANA_B: begin
        if (tick) begin
          if (ganCnt == GAN_W'(T_GANADOR - 1)) begin
            stateNext = APAGADO;
          end else begin
            ganCntNext = ganCnt + GAN_W'(1);
            ledsNext   = ~ledsReg;
          end
        end
      end
      default: stateNext = APAGADO;
    endcase

    if (bus.apagar) begin
      stateNext = APAGADO;
      restart   = 1'b0;
    end

    case (stateNext)
      CUENTA: ledsNext = {N_LEDS{cuentaNext[0]}};
      JUEGO: begin
        ledsNext   = N_LEDS'(1) << posNext;
        cuentaNext = '0;
      end
      GANA_A, GANA_B: begin
        cuentaNext = '0;
        if (!esGanador(state)) begin
          ledsNext   = '1;
          ganCntNext = '0;
        end
      end
      default: begin
        ledsNext   = '0;
        cuentaNext = '0;
      end
    endcase
  end

  // State, edge detectors and registered outputs.
  always_ff @(posedge clk or posedge resetTotal) begin
    if (resetTotal) begin
      state            <= APAGADO;
      pos              <= POS_INI;
      cuenta           <= '0;
      ganCnt           <= '0;
      ledsReg          <= '0;
      prevA            <= 1'b0;
      prevB            <= 1'b0;
      pulseA           <= 1'b0;
      pulseB           <= 1'b0;
      ganadorAReg      <= 1'b0;
      ganadorBReg      <= 1'b0;
      resetContadorReg <= 1'b1;
      jugandoReg       <= 1'b0;
    end else begin
      state            <= stateNext;
      pos              <= posNext;
      cuenta           <= cuentaNext;
      ganCnt           <= ganCntNext;
      ledsReg          <= ledsNext;
      prevA            <= bus.botonA;
      prevB            <= bus.botonB;
      pulseA           <= bus.botonA && !prevA;
      pulseB           <= bus.botonB && !prevB;
      ganadorAReg      <= (stateNext == GANA_A);
      ganadorBReg      <= (stateNext == GANA_B);
      resetContadorReg <= (stateNext == APAGADO);
      jugandoReg       <= (stateNext == JUEGO);
    end
  end

  assign bus.leds          = ledsReg;
  assign bus.cuenta        = cuenta;
  assign bus.ganadorA      = ganadorAReg;
  assign bus.ganadorB      = ganadorBReg;
  assign bus.resetContador = resetContadorReg;
  assign bus.jugando       = jugandoReg;

endmodule
